// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path.
// FSM state encoding, word width, lw/sw ALUops.
package mem_pkg;

  localparam int MEM_WORD_W = 32;

  localparam logic [4:0] ALUOP_LW = 5'b10100;
  localparam logic [4:0] ALUOP_SW = 5'b10101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM, registered read, no reset.
// Ports: i_clk, i_we, i_re, i_addr (word index), i_wdata, o_rdata.
module data_mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_addr,
  input  logic [MEM_WORD_W-1:0] i_wdata,
  output logic [MEM_WORD_W-1:0] o_rdata
);

  logic [MEM_WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [MEM_WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory responder: latched request, LAT wait states,
// one-cycle Ready_o/Err_o pulse, Stall_o for the whole access.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemCE_i,
  input  logic                  MemWE_i,
  input  logic [31:0]           MemAddr_i,
  input  logic [MEM_WORD_W-1:0] MemData_i,
  output logic [MEM_WORD_W-1:0] MemData_o,
  output logic                  Stall_o,
  output logic                  Ready_o,
  output logic                  Err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_t r_state;
  mem_state_t w_next;

  logic [3:0]            r_cnt;
  logic                  r_we;
  logic                  r_err;
  logic                  r_rd_ok;
  logic [AW-1:0]         r_idx;
  logic [MEM_WORD_W-1:0] r_wdata;

  logic                  w_stall;
  logic                  w_ready;
  logic                  w_access;
  logic                  w_in_err;
  logic                  w_accept;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic [MEM_WORD_W-1:0] w_rdata;

  // Misaligned, or beyond the array.
  assign w_in_err = (MemAddr_i[1:0] != 2'b00) ||
                    (MemAddr_i[31:AW+2] != '0);

  assign w_accept = (r_state == S_IDLE) && MemCE_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b0;
    w_ready  = 1'b0;
    w_access = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (MemCE_i) begin
          w_stall = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_ready = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(LAT - 1);
        r_we    <= MemWE_i;
        r_err   <= w_in_err;
        r_idx   <= MemAddr_i[AW+1:2];
        r_wdata <= MemData_i;
      end else if ((r_state == S_WAIT) &&
                   (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A bad read must show 0, a good one the RAM word.
      if (w_access && !r_we) r_rd_ok <= !r_err;
    end
  end

  // Gate with rst so a reset on the access edge drops the write.
  assign w_mem_we = w_access && r_we && !r_err && !rst;
  assign w_mem_re = w_access && !r_we && !r_err && !rst;

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .i_clk  (clk),
    .i_we   (w_mem_we),
    .i_re   (w_mem_re),
    .i_addr (r_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );

  // RAM holds its read register; r_rd_ok masks it to 0
  // after reset or a failed read.
  assign MemData_o = r_rd_ok ? w_rdata : '0;
  assign Stall_o   = w_stall;
  assign Ready_o   = w_ready;
  assign Err_o     = w_ready && r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl.
// dut_a: LAT=2, dut_b: LAT=1 (back-to-back).
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ce_a = 0, we_a = 0;
  logic [31:0] addr_a = 0, wd_a = 0, q_a;
  logic        st_a, rdy_a, err_a;

  logic        ce_b = 0, we_b = 0;
  logic [31:0] addr_b = 0, wd_b = 0, q_b;
  logic        st_b, rdy_b, err_b;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .MemCE_i(ce_a), .MemWE_i(we_a),
    .MemAddr_i(addr_a), .MemData_i(wd_a),
    .MemData_o(q_a), .Stall_o(st_a),
    .Ready_o(rdy_a), .Err_o(err_a)
  );

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .MemCE_i(ce_b), .MemWE_i(we_b),
    .MemAddr_i(addr_b), .MemData_i(wd_b),
    .MemData_o(q_b), .Stall_o(st_b),
    .Ready_o(rdy_b), .Err_o(err_b)
  );

  // Issue one request on dut_a, hold it until Ready_o.
  // rdy_at counts cycles from acceptance (t0 = 0).
  task automatic run_req(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  bit          chg,
    output int          stall_n,
    output int          rdy_at,
    output logic        e,
    output logic [31:0] q
  );
    stall_n = 0;
    rdy_at  = -1;
    e       = 1'bx;
    q       = 'x;
    @(posedge clk); #1;
    ce_a = 1; we_a = we; addr_a = a; wd_a = d;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (st_a) stall_n++;
      if (rdy_a) begin
        rdy_at = c;
        e = err_a;
        q = q_a;
        break;
      end
      if (chg && c == 0) begin
        @(posedge clk); #1;
        addr_a = 32'h20; wd_a = 32'h1;
      end
    end
    @(posedge clk); #1;
    ce_a = 0; we_a = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++;
    if (q_a !== 32'h0 || st_a !== 0 || rdy_a !== 0 || err_a !== 0) begin
      bad++;
      $display("FAIL reset_a: q=%h st=%b rdy=%b err=%b need 0",
               q_a, st_a, rdy_a, err_a);
    end
    vec++;
    if (q_b !== 32'h0 || st_b !== 0 || rdy_b !== 0) begin
      bad++;
      $display("FAIL reset_b: q=%h st=%b rdy=%b need 0",
               q_b, st_b, rdy_b);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_write_read;
    int sn, ra;
    logic e;
    logic [31:0] q;
    run_req(1, 32'h10, 32'hDEADBEEF, 0, sn, ra, e, q);
    vec++;
    if (sn !== 3) begin
      bad++;
      $display("FAIL sw_stall: got %0d need 3", sn);
    end
    vec++;
    if (ra !== 3 || e !== 0) begin
      bad++;
      $display("FAIL sw_ready: at=%0d err=%b need 3/0", ra, e);
    end
    run_req(0, 32'h10, 32'h0, 0, sn, ra, e, q);
    vec++;
    if (ra !== 3 || sn !== 3) begin
      bad++;
      $display("FAIL lw_timing: at=%0d stall=%0d need 3/3", ra, sn);
    end
    vec++;
    if (q !== 32'hDEADBEEF || e !== 0) begin
      bad++;
      $display("FAIL lw_data: q=%h err=%b need deadbeef/0", q, e);
    end
  endtask

  task automatic test_reset_mid;
    int sn, ra;
    logic e;
    logic [31:0] q;
    @(posedge clk); #1;
    ce_a = 1; we_a = 1; addr_a = 32'h10; wd_a = 32'h12345678;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1; ce_a = 0; we_a = 0;
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (dut_a.r_state !== S_IDLE) begin
      bad++;
      $display("FAIL rst_state: got %0d need 0", dut_a.r_state);
    end
    vec++;
    if (q_a !== 0 || st_a !== 0 || rdy_a !== 0 || err_a !== 0) begin
      bad++;
      $display("FAIL rst_outs: q=%h st=%b rdy=%b err=%b need 0",
               q_a, st_a, rdy_a, err_a);
    end
    @(posedge clk); #1;
    rst = 0;
    run_req(0, 32'h10, 32'h0, 0, sn, ra, e, q);
    vec++;
    if (q !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rst_nowrite: q=%h need deadbeef", q);
    end
  endtask

  task automatic test_wait_change;
    int sn, ra;
    logic e;
    logic [31:0] q;
    run_req(1, 32'h20, 32'h22222222, 0, sn, ra, e, q);
    run_req(1, 32'h14, 32'hA5A5A5A5, 1, sn, ra, e, q);
    vec++;
    if (ra !== 3) begin
      bad++;
      $display("FAIL chg_ready: at=%0d need 3", ra);
    end
    run_req(0, 32'h14, 32'h0, 0, sn, ra, e, q);
    vec++;
    if (q !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL chg_w14: q=%h need a5a5a5a5", q);
    end
    run_req(0, 32'h20, 32'h0, 0, sn, ra, e, q);
    vec++;
    if (q !== 32'h22222222) begin
      bad++;
      $display("FAIL chg_w20: q=%h need 22222222", q);
    end
  endtask

  task automatic test_misaligned;
    int sn, ra;
    logic e;
    logic [31:0] q;
    run_req(0, 32'h13, 32'h0, 0, sn, ra, e, q);
    vec++;
    if (ra !== 3 || e !== 1) begin
      bad++;
      $display("FAIL mis_err: at=%0d err=%b need 3/1", ra, e);
    end
    vec++;
    if (q !== 32'h0) begin
      bad++;
      $display("FAIL mis_data: q=%h need 0", q);
    end
  endtask

  task automatic test_out_of_range;
    int sn, ra;
    logic e;
    logic [31:0] q;
    run_req(1, 32'h0, 32'h11111111, 0, sn, ra, e, q);
    vec++;
    if (e !== 0) begin
      bad++;
      $display("FAIL sw0_err: err=%b need 0", e);
    end
    run_req(1, 32'h1000, 32'hCAFEF00D, 0, sn, ra, e, q);
    vec++;
    if (ra !== 3 || e !== 1) begin
      bad++;
      $display("FAIL oor_err: at=%0d err=%b need 3/1", ra, e);
    end
    run_req(0, 32'h0, 32'h0, 0, sn, ra, e, q);
    vec++;
    if (q !== 32'h11111111 || e !== 0) begin
      bad++;
      $display("FAIL oor_nowrite: q=%h err=%b need 11111111/0", q, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp_r = 6'b100100;
    logic [5:0] exp_s = 6'b011011;
    int ra;
    @(posedge clk); #1;
    ce_b = 1; we_b = 1; addr_b = 32'h4; wd_b = 32'h77;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++;
      if (rdy_b !== exp_r[c]) begin
        bad++;
        $display("FAIL b2b_ready t%0d: got %b need %b",
                 c, rdy_b, exp_r[c]);
      end
      vec++;
      if (st_b !== exp_s[c]) begin
        bad++;
        $display("FAIL b2b_stall t%0d: got %b need %b",
                 c, st_b, exp_s[c]);
      end
    end
    @(posedge clk); #1;
    ce_b = 0; we_b = 0;
    @(posedge clk); #1;
    ce_b = 1; addr_b = 32'h4;
    ra = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rdy_b) begin
        ra = c;
        break;
      end
    end
    vec++;
    if (ra !== 2 || q_b !== 32'h77) begin
      bad++;
      $display("FAIL b2b_read: at=%0d q=%h need 2/77", ra, q_b);
    end
    @(posedge clk); #1;
    ce_b = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid();
    test_wait_change();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
